salu_branch_unit: RTL and testbench

//  Parametrised, pipelined SOPP branch resolver for the scalar ALU path. Accepts branch instructions from

---
 rtl/salu_pkg.sv | 18 +
 rtl/salu_branch_fifo.sv | 58 +++++
 rtl/salu_branch_unit.sv | 163 ++++++++++++++++
 tb/tb_salu_branch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/salu_pkg.sv
// Shared SOPP encodings and the branch-entry layout used by the branch resolver.
package salu_pkg;

  localparam logic [7:0]  SOPP_ENC            = 8'h01;
  localparam logic [23:0] SOPP_BRANCH         = 24'd2;
  localparam logic [23:0] SOPP_CBRANCH_SCC0   = 24'd4;
  localparam logic [23:0] SOPP_CBRANCH_SCC1   = 24'd5;
  localparam logic [23:0] SOPP_CBRANCH_VCCZ   = 24'd6;
  localparam logic [23:0] SOPP_CBRANCH_VCCNZ  = 24'd7;
  localparam logic [23:0] SOPP_CBRANCH_EXECZ  = 24'd8;
  localparam logic [23:0] SOPP_CBRANCH_EXECNZ = 24'd9;

  // Entry is packed {wfid, taken, next_pc, pc}, with pc in the low bits.
  function automatic int entry_w(input int wfid_w, input int pc_w);
    return wfid_w + 1 + 2 * pc_w;
  endfunction

endpackage

// File: rtl/salu_branch_fifo.sv
// Synchronous FIFO with occupancy count; when empty, dout keeps showing the last popped word.
module salu_branch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [AW:0]                 count_q, count_d;
  logic [AW-1:0]               rd_prev;
  logic                        do_pop;

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  assign rd_prev = rd_ptr_q - AW'(1);
  // The slot just behind rd_ptr is not rewritten until the queue wraps, so it holds the last pop.
  assign dout    = empty ? mem_q[rd_prev] : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/salu_branch_unit.sv
// Pipelined SOPP branch resolver: decode and target at accept, LATENCY register stages, output queue.
module salu_branch_unit
  import salu_pkg::*;
#(
  parameter int WFID_W    = 6,
  parameter int PC_W      = 32,
  parameter int MASK_W    = 64,
  parameter int LATENCY   = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_branch_valid,
  output logic              issue_branch_ready,
  input  logic [31:0]       issue_opcode,
  input  logic [15:0]       issue_imm_value,
  input  logic [WFID_W-1:0] issue_wfid,
  input  logic [PC_W-1:0]   issue_instr_pc,
  output logic              exec_rd_en,
  output logic [WFID_W-1:0] exec_rd_wfid,
  input  logic              exec_rd_scc_value,
  input  logic [MASK_W-1:0] exec_rd_vcc_value,
  input  logic [MASK_W-1:0] exec_rd_exec_value,
  output logic              fetchwaveissue_branch_en,
  input  logic              fetch_branch_ready,
  output logic [WFID_W-1:0] fetchwaveissue_branch_wfid,
  output logic              fetchwaveissue_branch_taken,
  output logic [PC_W-1:0]   fetch_branch_pc_value,
  output logic [PC_W-1:0]   tracemon_retire_pc,
  output logic              err_dup_wfid,
  output logic              err_bad_opcode
);

  localparam int NUM_WF = 2 ** WFID_W;
  localparam int ENT_W  = entry_w(WFID_W, PC_W);
  localparam int CW     = $clog2(OUT_DEPTH) + 1;
  localparam int QAW    = $clog2(OUT_DEPTH);

  logic                   accept, pop;
  logic                   taken, bad_op;
  logic [23:0]            op;
  logic [PC_W-1:0]        pc_plus4, br_off, target, next_pc;
  logic [ENT_W-1:0]       ent_s0, head;
  logic                   q_empty;
  logic [QAW:0]           q_count;
  logic [WFID_W-1:0]      head_wfid;

  logic [LATENCY:1]       vld_pipe_q, vld_pipe_d;
  logic [LATENCY:1][ENT_W-1:0] ent_pipe_q, ent_pipe_d;
  logic [CW-1:0]          used_q, used_d;
  logic                   ready_q, ready_d;
  logic [NUM_WF-1:0]      pend_q, pend_d;
  logic                   dup_q, dup_d;
  logic                   bad_q, bad_d;

  assign accept       = issue_branch_valid & ready_q;
  assign exec_rd_en   = issue_branch_valid;
  assign exec_rd_wfid = issue_wfid;
  assign op           = issue_opcode[23:0];

  always_comb begin
    taken  = 1'b0;
    bad_op = 1'b0;
    if (issue_opcode[31:24] != SOPP_ENC) begin
      bad_op = 1'b1;
    end else begin
      case (op)
        SOPP_BRANCH:         taken = 1'b1;
        SOPP_CBRANCH_SCC0:   taken = ~exec_rd_scc_value;
        SOPP_CBRANCH_SCC1:   taken = exec_rd_scc_value;
        SOPP_CBRANCH_VCCZ:   taken = ~|exec_rd_vcc_value;
        SOPP_CBRANCH_VCCNZ:  taken = |exec_rd_vcc_value;
        SOPP_CBRANCH_EXECZ:  taken = ~|exec_rd_exec_value;
        SOPP_CBRANCH_EXECNZ: taken = |exec_rd_exec_value;
        default:             bad_op = 1'b1;
      endcase
    end
  end

  // simm16 is a word offset relative to pc+4; the sums wrap naturally at PC_W.
  assign pc_plus4 = issue_instr_pc + PC_W'(4);
  assign br_off   = {{(PC_W-18){issue_imm_value[15]}}, issue_imm_value, 2'b00};
  assign target   = pc_plus4 + br_off;
  assign next_pc  = taken ? target : pc_plus4;
  assign ent_s0   = {issue_wfid, taken, next_pc, issue_instr_pc};

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    ent_pipe_d    = ent_pipe_q;
    vld_pipe_d[1] = accept;
    ent_pipe_d[1] = ent_s0;
    for (int i = 2; i <= LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      ent_pipe_d[i] = ent_pipe_q[i-1];
    end
  end

  salu_branch_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(ENT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_pipe_q[LATENCY]),
    .din   (ent_pipe_q[LATENCY]),
    .pop   (pop),
    .dout  (head),
    .empty (q_empty),
    .count (q_count)
  );

  assign fetchwaveissue_branch_en    = ~q_empty;
  assign pop                         = ~q_empty & fetch_branch_ready;
  assign head_wfid                   = head[ENT_W-1 -: WFID_W];
  assign fetchwaveissue_branch_wfid  = head_wfid;
  assign fetchwaveissue_branch_taken = head[2*PC_W];
  assign fetch_branch_pc_value       = head[2*PC_W-1 -: PC_W];
  assign tracemon_retire_pc          = head[PC_W-1:0];

  // Credits cover queued plus in-flight entries, so the pipe never needs to stall.
  always_comb begin
    used_d  = used_q + CW'(accept) - CW'(pop);
    ready_d = (used_d < CW'(OUT_DEPTH));
  end

  // A pop clears before an accept sets, so a same-cycle retire/reissue of one wf is not a dup.
  always_comb begin
    pend_d = pend_q;
    dup_d  = dup_q;
    bad_d  = bad_q;
    if (pop) pend_d[head_wfid] = 1'b0;
    if (accept) begin
      if (pend_d[issue_wfid]) dup_d = 1'b1;
      pend_d[issue_wfid] = 1'b1;
      if (bad_op) bad_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      ent_pipe_q <= '0;
      used_q     <= '0;
      ready_q    <= 1'b1;
      pend_q     <= '0;
      dup_q      <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      ent_pipe_q <= ent_pipe_d;
      used_q     <= used_d;
      ready_q    <= ready_d;
      pend_q     <= pend_d;
      dup_q      <= dup_d;
      bad_q      <= bad_d;
    end
  end

  assign issue_branch_ready = ready_q;
  assign err_dup_wfid       = dup_q;
  assign err_bad_opcode     = bad_q;

  logic unused_ok;
  assign unused_ok = ^q_count;

endmodule

// File: tb/tb_salu_branch_unit.sv
// Directed-vector bench for salu_branch_unit with a queue scoreboard checked by a separate monitor.
module tb_salu_branch_unit;
  localparam int WFID_W = 6, PC_W = 32, MASK_W = 64, LATENCY = 2, OUT_DEPTH = 4;

  logic              clk = 0, rst = 0;
  logic              issue_branch_valid = 0, issue_branch_ready;
  logic [31:0]       issue_opcode = 0;
  logic [15:0]       issue_imm_value = 0;
  logic [WFID_W-1:0] issue_wfid = 0;
  logic [PC_W-1:0]   issue_instr_pc = 0;
  logic              exec_rd_en;
  logic [WFID_W-1:0] exec_rd_wfid;
  logic              exec_rd_scc_value = 0;
  logic [MASK_W-1:0] exec_rd_vcc_value = 0, exec_rd_exec_value = 0;
  logic              fetchwaveissue_branch_en, fetch_branch_ready = 0;
  logic [WFID_W-1:0] fetchwaveissue_branch_wfid;
  logic              fetchwaveissue_branch_taken;
  logic [PC_W-1:0]   fetch_branch_pc_value, tracemon_retire_pc;
  logic              err_dup_wfid, err_bad_opcode;

  typedef struct {
    logic [WFID_W-1:0] wfid;
    logic              taken;
    logic [PC_W-1:0]   npc;
    logic [PC_W-1:0]   pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;

  salu_branch_unit #(.WFID_W(WFID_W), .PC_W(PC_W), .MASK_W(MASK_W),
                     .LATENCY(LATENCY), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .issue_branch_valid(issue_branch_valid), .issue_branch_ready(issue_branch_ready),
    .issue_opcode(issue_opcode), .issue_imm_value(issue_imm_value),
    .issue_wfid(issue_wfid), .issue_instr_pc(issue_instr_pc),
    .exec_rd_en(exec_rd_en), .exec_rd_wfid(exec_rd_wfid),
    .exec_rd_scc_value(exec_rd_scc_value), .exec_rd_vcc_value(exec_rd_vcc_value),
    .exec_rd_exec_value(exec_rd_exec_value),
    .fetchwaveissue_branch_en(fetchwaveissue_branch_en), .fetch_branch_ready(fetch_branch_ready),
    .fetchwaveissue_branch_wfid(fetchwaveissue_branch_wfid),
    .fetchwaveissue_branch_taken(fetchwaveissue_branch_taken),
    .fetch_branch_pc_value(fetch_branch_pc_value), .tracemon_retire_pc(tracemon_retire_pc),
    .err_dup_wfid(err_dup_wfid), .err_bad_opcode(err_bad_opcode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every pop is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (rst && fetchwaveissue_branch_en && fetch_branch_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got wfid %0d pc %h, expected no entry",
                 fetchwaveissue_branch_wfid, tracemon_retire_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (fetchwaveissue_branch_wfid !== e.wfid || fetchwaveissue_branch_taken !== e.taken ||
            fetch_branch_pc_value !== e.npc || tracemon_retire_pc !== e.pc) begin
          errors++;
          $display("FAIL pop_entry: got wfid %0d taken %b npc %h pc %h, expected wfid %0d taken %b npc %h pc %h",
                   fetchwaveissue_branch_wfid, fetchwaveissue_branch_taken, fetch_branch_pc_value,
                   tracemon_retire_pc, e.wfid, e.taken, e.npc, e.pc);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] opc, input logic [15:0] imm, input int wf,
                       input logic [31:0] pc, input logic scc, input logic [63:0] vcc,
                       input logic [63:0] ex, input logic exp_taken, input logic [31:0] exp_npc);
    int waited = 0;
    issue_branch_valid = 1; issue_opcode = opc; issue_imm_value = imm;
    issue_wfid = WFID_W'(wf); issue_instr_pc = pc;
    exec_rd_scc_value = scc; exec_rd_vcc_value = vcc; exec_rd_exec_value = ex;
    while (!issue_branch_ready && waited < 100) begin
      @(posedge clk); #1; waited++;
    end
    if (!issue_branch_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got ready 0 for 100 cycles, expected 1");
      issue_branch_valid = 0;
      return;
    end
    @(posedge clk);
    sb.push_back('{wfid: WFID_W'(wf), taken: exp_taken, npc: exp_npc, pc: pc});
    #1 issue_branch_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    fetch_branch_ready = 1;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d entries left, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", issue_branch_ready, 1);
    check("rst_en", fetchwaveissue_branch_en, 0);
    check("rst_outs", {fetchwaveissue_branch_wfid, fetchwaveissue_branch_taken,
                       fetch_branch_pc_value, tracemon_retire_pc, err_dup_wfid, err_bad_opcode}, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;

    // Unconditional branch, and accept-to-en latency
    fetch_branch_ready = 1;
    issue(32'h01000002, 16'd10, 2, 32'd64, 0, 0, 0, 1, 32'h6C);
    n = 0;
    do begin @(negedge clk); n++; end while (!fetchwaveissue_branch_en && n < 20);
    check("latency", n, LATENCY + 1);
    check("exec_rd_idle", exec_rd_en, 0);
    drain();

    // Condition codes
    issue(32'h01000006, 16'd10, 7, 32'd64, 0, 64'h0, 0, 1, 32'h6C);
    issue(32'h01000006, 16'd10, 8, 32'd64, 0, 64'h1, 0, 0, 32'h44);
    issue(32'h01000004, 16'd1, 9, 32'h100, 0, 0, 0, 1, 32'h108);
    issue(32'h01000004, 16'd1, 10, 32'h100, 1, 0, 0, 0, 32'h104);
    issue(32'h01000005, 16'd2, 11, 32'h200, 1, 0, 0, 1, 32'h20C);
    issue(32'h01000007, 16'd2, 12, 32'h200, 0, 64'h8000_0000_0000_0000, 0, 1, 32'h20C);
    issue(32'h01000008, 16'd3, 13, 32'h300, 0, 0, 64'h0, 1, 32'h310);
    issue(32'h01000009, 16'd3, 14, 32'h300, 0, 0, 64'h0, 0, 32'h304);
    drain();

    // PC wrap
    issue(32'h01000002, 16'h0000, 20, 32'hFFFFFFFC, 0, 0, 0, 1, 32'h0);
    issue(32'h01000002, 16'hFFFF, 21, 32'h0, 0, 0, 0, 1, 32'h0);
    issue(32'h01000002, 16'h8000, 22, 32'h0, 0, 0, 0, 1, 32'hFFFE0004);
    drain();

    // Back-pressure: 4 credits, then stall until the consumer pops
    fetch_branch_ready = 0;
    for (int i = 0; i < 4; i++) issue(32'h01000002, 16'd0, i, 32'h1000 + 32'(i*16), 0, 0, 0, 1, 32'h1004 + 32'(i*16));
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("full_ready", issue_branch_ready, 0);
    check("full_en", fetchwaveissue_branch_en, 1);
    check("full_head", fetchwaveissue_branch_wfid, 0);
    @(posedge clk); #1 fetch_branch_ready = 1;
    for (int i = 4; i < 6; i++) issue(32'h01000002, 16'd0, i, 32'h1000 + 32'(i*16), 0, 0, 0, 1, 32'h1004 + 32'(i*16));
    drain();
    check("no_dup_yet", err_dup_wfid, 0);
    check("no_bad_yet", err_bad_opcode, 0);

    // Duplicate wfid and bad opcode flags
    fetch_branch_ready = 0;
    issue(32'h01000002, 16'd0, 3, 32'h2000, 0, 0, 0, 1, 32'h2004);
    issue(32'h01000002, 16'd0, 3, 32'h2010, 0, 0, 0, 1, 32'h2014);
    @(negedge clk);
    check("dup_set", err_dup_wfid, 1);
    drain();
    issue(32'h0100000A, 16'd5, 30, 32'h3000, 1, 1, 1, 0, 32'h3004);
    issue(32'h02000002, 16'd5, 31, 32'h3100, 1, 1, 1, 0, 32'h3104);
    drain();
    check("dup_sticky", err_dup_wfid, 1);
    check("bad_set", err_bad_opcode, 1);

    // Reset with queued entries
    fetch_branch_ready = 0;
    for (int i = 0; i < 3; i++) issue(32'h01000002, 16'd0, 40 + i, 32'h4000 + 32'(i*4), 0, 0, 0, 1, 32'h4004 + 32'(i*4));
    repeat (4) @(posedge clk);
    #1 rst = 0;
    #1;
    check("rst_mid_en", fetchwaveissue_branch_en, 0);
    check("rst_mid_ready", issue_branch_ready, 1);
    check("rst_mid_err", {err_dup_wfid, err_bad_opcode}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1; fetch_branch_ready = 1;
    n = 0;
    repeat (8) begin @(negedge clk); if (fetchwaveissue_branch_en) n++; end
    check("no_stale", n, 0);
    issue(32'h01000005, 16'd4, 41, 32'h5000, 1, 0, 0, 1, 32'h5014);
    drain();
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end
endmodule
